// File: rtl/register_file_staged.sv
// 32-entry MIPS register file with a one-entry write staging register.
// Define REGFILE_BYPASS_EN to forward incoming and staged writes onto the read ports.
module register_file_staged #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic                  pending
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  logic                  stg_valid_q, stg_valid_d;
  logic [ADDR_WIDTH-1:0] stg_addr_q,  stg_addr_d;
  logic [DATA_WIDTH-1:0] stg_data_q,  stg_data_d;

  // Writes to register 0 are dropped here, so a valid stage never targets it.
  always_comb begin
    stg_valid_d = we && (wa != '0);
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    if (stg_valid_d) begin
      stg_addr_d = wa;
      stg_data_d = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      if (stg_valid_q) begin
        regs_q[stg_addr_q] <= stg_data_q;
      end
    end
  end

  assign pending = stg_valid_q;

  always_comb begin
    rd1 = regs_q[ra1];
`ifdef REGFILE_BYPASS_EN
    if (stg_valid_q && (stg_addr_q == ra1)) rd1 = stg_data_q;
    if (we && (wa == ra1))                  rd1 = wd;
`endif
    if (ra1 == '0) rd1 = '0;
  end

  always_comb begin
    rd2 = regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
    if (stg_valid_q && (stg_addr_q == ra2)) rd2 = stg_data_q;
    if (we && (wa == ra2))                  rd2 = wd;
`endif
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: tb/tb_register_file_staged.sv
// Randomized bench for register_file_staged against a timestamped write-log model.
module tb_register_file_staged;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset, we, pending;
  logic [AW-1:0] wa, ra1, ra2;
  logic [DW-1:0] wd, rd1, rd2;

  always #5 clk = ~clk;

  register_file_staged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .pending(pending)
  );

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           log_q[$];
  logic [DW-1:0] mem [DEPTH];
  int unsigned   cyc;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A write accepted in cycle c reaches the array from cycle c+2.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    if (ra == 0) return '0;
    v = mem[ra];
`ifdef REGFILE_BYPASS_EN
    foreach (log_q[i])
      if (log_q[i].cyc + 1 == cyc && log_q[i].addr == ra) v = log_q[i].data;
    if (we && wa == ra) v = wd;
`endif
    return v;
  endfunction

  function automatic logic exp_pending();
    foreach (log_q[i]) if (log_q[i].cyc + 1 == cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2, input bit chk, input string tag);
    @(negedge clk);
    reset = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    #1;
    if (chk) begin
      check({tag, ":rd1"}, rd1, exp_read(r1));
      check({tag, ":rd2"}, rd2, exp_read(r2));
      check({tag, ":pending"}, {31'b0, pending}, {31'b0, exp_pending()});
    end
    @(posedge clk);
    if (r) begin
      log_q.delete();
      foreach (mem[i]) mem[i] = '0;
    end else if (w && a != 0) begin
      log_q.push_back('{cyc, a, d});
    end
    cyc++;
    while (log_q.size() > 0 && log_q[0].cyc + 2 <= cyc) begin
      mem[log_q[0].addr] = log_q[0].data;
      void'(log_q.pop_front());
    end
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input string tag);
    step(1'b0, 1'b0, '0, '0, r1, r2, 1'b1, tag);
  endtask

  initial begin
    logic [AW-1:0] a, r1, r2;
    logic [DW-1:0] d;
    logic          w, r;
    cyc = 0;
    foreach (mem[i]) mem[i] = '0;
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, "init");
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b1, "init_rst");

    // Preload, reset, then sweep all addresses on both ports.
    for (int i = 1; i < DEPTH; i++) begin
      a = AW'(i);
      step(1'b0, 1'b1, a, $urandom, a, AW'(i - 1), 1'b1, "preload");
    end
    step(1'b1, 1'b0, '0, '0, 5'd3, 5'd31, 1'b1, "rst_pulse");
    for (int i = 0; i < DEPTH; i++) begin
      idle(AW'(i), AW'(DEPTH - 1 - i), "sweep");
      check("sweep_zero", rd1 | rd2, '0);
    end

    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, "lat_w");
    for (int i = 0; i < 3; i++) idle(5'd5, 5'd5, "lat");
    check("lat_final", rd1, 32'hDEADBEEF);

    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "r0_w");
    for (int i = 0; i < 2; i++) idle(5'd0, 5'd0, "r0");

    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 5'd7, DW'(i), 5'd7, 5'd7, 1'b1, "b2b_w");
    for (int i = 0; i < 3; i++) idle(5'd7, 5'd7, "b2b");
    check("b2b_final", rd1, 32'd3);

    step(1'b0, 1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, 1'b1, "rstmid_w");
    step(1'b1, 1'b0, '0, '0, 5'd9, 5'd9, 1'b1, "rstmid_r");
    for (int i = 0; i < 2; i++) idle(5'd9, 5'd9, "rstmid");
    check("rstmid_zero", rd1, '0);

    step(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 1'b1, "byp_a");
    step(1'b0, 1'b1, 5'd3, 32'h5A5A5A5A, 5'd3, 5'd0, 1'b1, "byp_b");
    for (int i = 0; i < 3; i++) idle(5'd3, 5'd0, "byp");

    step(1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 5'd4, 5'd4, 1'b1, "we_rst");
    for (int i = 0; i < 2; i++) idle(5'd4, 5'd4, "we_rst_after");

    // Narrow address range in half the cycles to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      bit narrow = ($urandom_range(0, 1) == 1);
      a  = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      r1 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      r2 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      w  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 49) == 0);
      d  = $urandom;
      step(r, w, a, d, r1, r2, 1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
